data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 128, giving the data RAM depth in 32-bit words (power of two, at most 256).
REQ-002 The block SHALL have parameter RAM_BASE, default 32'h0000_0800, giving the byte base address of the data RAM.
REQ-003 The block SHALL have parameter IO_BASE, default 32'h0000_0C00, giving the byte base address of the 4-register I/O window.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 MemWrite  input  1  write strobe from the core memory stage.
REQ-007 Addr  input  32  byte address (the core's OpResult).
REQ-008 WriteData  input  32  store data.
REQ-009 ReadData  output  32  load data returned to the core.
REQ-010 DIP  input  16  asynchronous switch inputs.
REQ-011 LED  output  8  LED register contents.
REQ-012 FaultCount  output  16  current fault counter value.

Function
REQ-013 Address map, word index = Addr[31:2]:
- RAM occupies RAM_BASE .. RAM_BASE+4*RAM_WORDS-1, indexed by (Addr-RAM_BASE)>>2.
- IO_BASE+0x0 is LED (RW, bits [7:0]).
- IO_BASE+0x4 is DIP (RO, synchronized value zero-extended).
- IO_BASE+0x8 is CYCLE (RO 32-bit counter; any write clears it).
- IO_BASE+0xC is FAULT (RO, zero-extended FaultCount).
REQ-014 ReadData SHALL be combinational from Addr in the same cycle (zero wait states); Addr[1:0] is ignored on reads.
REQ-015 A read of any unmapped address SHALL return 32'h0000_0000 and SHALL NOT count as a fault.
REQ-016 A write SHALL take effect at the rising edge where MemWrite=1; a same-cycle read of that address SHALL return the pre-write value.
REQ-017 A RAM write SHALL store all 32 bits; a LED write SHALL store WriteData[7:0].
REQ-018 A write to CYCLE SHALL make CYCLE read 0 in the next cycle; clear has priority over increment.
REQ-019 CYCLE SHALL otherwise increment by 1 every cycle, wrapping from 32'hFFFF_FFFF to 0.
REQ-020 The DIP value SHALL pass through two synchronizing flops; a DIP change is visible on reads exactly 2 cycles after it is sampled.
REQ-021 A fault is MemWrite=1 with any of:
- Addr[1:0]!=0;
- Addr unmapped;
- Addr targeting DIP or FAULT.
REQ-022 A faulting write SHALL modify no storage (RAM, LED, CYCLE), and FaultCount SHALL increment by 1 at that edge.
REQ-023 FaultCount SHALL saturate at 16'hFFFF.
REQ-024 A misaligned write to the CYCLE address SHALL be a fault and SHALL NOT clear CYCLE.
REQ-025 MemWrite with X-free Addr SHALL decode to at most one target.
REQ-026 The RAM and the I/O window SHALL NOT overlap for legal parameters; overlapping parameters are a configuration error that an elaboration-time check SHALL flag.

Reset
REQ-027 With Reset=1 at an edge: LED=0, CYCLE=0, FaultCount=0, synchronizer flops=0.
REQ-028 RAM contents SHALL NOT be reset; they are undefined until written.
REQ-029 Reset SHALL have priority over every write, fault and increment in the same cycle; a write asserted with Reset=1 is discarded and not counted.
REQ-030 In the first cycle after Reset deasserts, CYCLE SHALL read 0, then 1 in the following cycle.

Verification
REQ-031 RAM round-trip: write 32'hDEADBEEF to 0x804, then read 0x804 and 0x806 -> both return 32'hDEADBEEF; same-cycle read during the write returns the old value.
REQ-032 LED/unmapped: write 32'h1234_56A5 to 0xC00 -> LED=8'hA5 and read 0xC00 = 32'h0000_00A5; read 0x0000_4000 -> 0 with FaultCount unchanged.
REQ-033 Faults: writes to 0xC04, 0xC0C, 0x0000_4000 and 0x805 -> FaultCount=4 and no storage changed; force FaultCount to 16'hFFFF, fault again -> stays 16'hFFFF.
REQ-034 CYCLE: release Reset, read 0xC08 on consecutive cycles -> 0,1,2; write 0xC08 -> next read 0; misaligned write to 0xC09 -> no clear, FaultCount+1.
REQ-035 DIP sync: DIP changes 0->16'hBEEF before edge N -> reads of 0xC04 return 0 at cycles N and N+1 and 32'h0000_BEEF from cycle N+2.
REQ-036 Reset mid-operation: assert Reset together with a write of 8'h3C to LED while LED=8'hFF and FaultCount=7 -> after the edge LED=0, FaultCount=0, CYCLE=0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Purpose : core memory-stage bus between a load/store master and the data memory responder.
// Latency : read_data is combinational from addr in the same cycle; writes commit at the next clock edge.
// Backpressure: none; the responder accepts one access every cycle (zero wait states).
// Signals : mem_write (write strobe), addr (byte address), write_data (store data), read_data (load data).
interface data_mem_responder_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output mem_write,
    output addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  mem_write,
    input  addr,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose : data RAM plus a 4-register I/O window (LED, DIP, CYCLE, FAULT) behind the core memory stage.
// Latency : reads are combinational (zero wait states); writes, counters and faults update at the clock edge.
// Backpressure: none; every cycle is accepted, and illegal writes are dropped and counted as faults.
// Ports   : i_clk, i_reset (sync, active high), io_bus (slave side of the memory bus),
//           i_dip (async switches), o_led (LED register), o_fault_count (saturating fault counter).
module data_mem_responder #(
  parameter int          RAM_WORDS = 128,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0800,
  parameter logic [31:0] IO_BASE   = 32'h0000_0C00
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  data_mem_responder_if.slave  io_bus,
  input  logic [15:0]          i_dip,
  output logic [7:0]           o_led,
  output logic [15:0]          o_fault_count
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Configuration sanity: the RAM and the 16-byte I/O window must be disjoint,
  // the RAM depth a power of two no larger than 256, and both bases aligned.
  localparam longint RAM_LO = longint'(RAM_BASE);
  localparam longint RAM_HI = RAM_LO + 4 * longint'(RAM_WORDS);
  localparam longint IO_LO  = longint'(IO_BASE);
  localparam longint IO_HI  = IO_LO + 16;
  localparam bit CFG_OVERLAP = (RAM_LO < IO_HI) && (IO_LO < RAM_HI);
  localparam bit CFG_DEPTH   = (RAM_WORDS < 1) || (RAM_WORDS > 256) ||
                               ((RAM_WORDS & (RAM_WORDS - 1)) != 0);
  localparam bit CFG_ALIGN   = (RAM_BASE[1:0] != 2'b00) || (IO_BASE[3:0] != 4'h0);

  if (CFG_OVERLAP) begin : g_cfg_overlap
    $error("data_mem_responder: RAM and I/O window overlap");
  end
  if (CFG_DEPTH) begin : g_cfg_depth
    $error("data_mem_responder: RAM_WORDS must be a power of two in 1..256");
  end
  if (CFG_ALIGN) begin : g_cfg_align
    $error("data_mem_responder: RAM_BASE must be word aligned, IO_BASE 16-byte aligned");
  end

  // ---------------------------------------------------------------- decode
  logic [29:0]   w_word;
  logic [29:0]   w_ram_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_ram_hit;
  logic          w_io_hit;
  logic [1:0]    w_io_sel;
  logic          w_led_hit;
  logic          w_dip_hit;
  logic          w_cyc_hit;
  logic          w_flt_hit;
  logic          w_misaligned;
  logic          w_wr_fault;
  logic          w_wr_ok;

  // Decode on the word index so that reads ignore addr[1:0]; misalignment is
  // only relevant to writes and is handled by the fault logic.
  assign w_word    = io_bus.addr[31:2];
  // Unsigned offset: addresses below RAM_BASE wrap to a huge value and miss.
  assign w_ram_off = w_word - RAM_BASE[31:2];
  assign w_ram_idx = w_ram_off[AW-1:0];
  assign w_ram_hit = (w_ram_off < 30'(RAM_WORDS));
  assign w_io_hit  = (io_bus.addr[31:4] == IO_BASE[31:4]);
  assign w_io_sel  = w_word[1:0];
  assign w_led_hit = w_io_hit && (w_io_sel == 2'd0);
  assign w_dip_hit = w_io_hit && (w_io_sel == 2'd1);
  assign w_cyc_hit = w_io_hit && (w_io_sel == 2'd2);
  assign w_flt_hit = w_io_hit && (w_io_sel == 2'd3);

  assign w_misaligned = (io_bus.addr[1:0] != 2'b00);
  assign w_wr_fault   = io_bus.mem_write &&
                        (w_misaligned || !(w_ram_hit || w_io_hit) || w_dip_hit || w_flt_hit);
  // Reset discards any write issued in the same cycle.
  assign w_wr_ok      = io_bus.mem_write && !w_wr_fault && !i_reset;

  // ---------------------------------------------------------------- storage
  logic [31:0] r_ram [RAM_WORDS];
  logic [7:0]  r_led;
  logic [31:0] r_cycle;
  logic [15:0] r_fault_cnt;
  logic [15:0] r_dip_s1;
  logic [15:0] r_dip_s2;

  // RAM is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && w_ram_hit) begin
      r_ram[w_ram_idx] <= io_bus.write_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_led       <= 8'h00;
      r_cycle     <= 32'h0000_0000;
      r_fault_cnt <= 16'h0000;
      r_dip_s1    <= 16'h0000;
      r_dip_s2    <= 16'h0000;
    end else begin
      r_dip_s1 <= i_dip;
      r_dip_s2 <= r_dip_s1;

      if (w_wr_ok && w_led_hit) begin
        r_led <= io_bus.write_data[7:0];
      end

      // Clear wins over the free-running increment.
      if (w_wr_ok && w_cyc_hit) begin
        r_cycle <= 32'h0000_0000;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end

      if (w_wr_fault && (r_fault_cnt != 16'hFFFF)) begin
        r_fault_cnt <= r_fault_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    io_bus.read_data = 32'h0000_0000;
    if (w_ram_hit) begin
      io_bus.read_data = r_ram[w_ram_idx];
    end else if (w_io_hit) begin
      case (w_io_sel)
        2'd0:    io_bus.read_data = {24'h00_0000, r_led};
        2'd1:    io_bus.read_data = {16'h0000, r_dip_s2};
        2'd2:    io_bus.read_data = r_cycle;
        default: io_bus.read_data = {16'h0000, r_fault_cnt};
      endcase
    end
  end

  assign o_led         = r_led;
  assign o_fault_count = r_fault_cnt;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int          RAM_WORDS = 128;
  localparam logic [31:0] RAM_BASE  = 32'h0000_0800;
  localparam logic [31:0] IO_BASE   = 32'h0000_0C00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dip;
  logic [7:0]  led;
  logic [15:0] fault_count;

  data_mem_responder_if bif ();

  data_mem_responder #(
    .RAM_WORDS(RAM_WORDS),
    .RAM_BASE (RAM_BASE),
    .IO_BASE  (IO_BASE)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .io_bus       (bif),
    .i_dip        (dip),
    .o_led        (led),
    .o_fault_count(fault_count)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state of the memory map.
  logic [31:0] m_ram [int];
  logic [7:0]  m_led;
  logic [31:0] m_cycle;
  logic [15:0] m_fault;
  logic [15:0] m_dipq [$];   // DIP samples taken at recent edges, oldest first
  bit          m_live = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_rd;

  function automatic bit in_ram(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(RAM_BASE);
    return (off >= 0) && (off < 4 * RAM_WORDS);
  endfunction

  function automatic bit in_io(input logic [31:0] a);
    return (a >= IO_BASE) && (a < IO_BASE + 32'd16);
  endfunction

  function automatic logic [15:0] dip_visible();
    // A sample becomes readable once a second edge has passed after it.
    if (m_dipq.size() >= 2) return m_dipq[0];
    return 16'h0000;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
    logic [31:0] aa;
    int          sel;
    aa    = {a[31:2], 2'b00};
    known = 1'b1;
    if (in_ram(aa)) begin
      sel = int'((aa - RAM_BASE) >> 2);
      if (m_ram.exists(sel)) return m_ram[sel];
      known = 1'b0;
      return 32'h0;
    end
    if (in_io(aa)) begin
      sel = int'((aa - IO_BASE) >> 2);
      case (sel)
        0:       return {24'h0, m_led};
        1:       return {16'h0, dip_visible()};
        2:       return m_cycle;
        default: return {16'h0, m_fault};
      endcase
    end
    return 32'h0;
  endfunction

  function automatic bit is_fault(input bit we, input logic [31:0] a);
    if (!we) return 1'b0;
    if (a[1:0] != 2'b00) return 1'b1;
    if (!(in_ram(a) || in_io(a))) return 1'b1;
    return (a == IO_BASE + 32'd4) || (a == IO_BASE + 32'd12);
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [15:0] d);
    bit clr;
    clr = 1'b0;
    if (rst) begin
      m_led   = 8'h00;
      m_cycle = 32'h0;
      m_fault = 16'h0;
      m_dipq.delete();
      m_live  = 1'b1;
    end else begin
      if (is_fault(we, a)) begin
        if (m_fault != 16'hFFFF) m_fault = m_fault + 16'd1;
      end else if (we) begin
        if (in_ram(a))                    m_ram[int'((a - RAM_BASE) >> 2)] = wd;
        else if (a == IO_BASE)            m_led = wd[7:0];
        else if (a == IO_BASE + 32'd8)    clr = 1'b1;
      end
      m_cycle = clr ? 32'h0 : m_cycle + 32'd1;
      m_dipq.push_back(d);
      if (m_dipq.size() > 2) void'(m_dipq.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, sample mid-cycle against the model, then advance the model at the edge.
  task automatic step(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input bit do_chk);
    logic [31:0] e;
    bit          known;
    reset          = rst;
    bif.mem_write  = we;
    bif.addr       = a;
    bif.write_data = wd;
    @(negedge clk);
    last_rd = bif.read_data;
    if (do_chk && m_live) begin
      e = exp_read(a, known);
      if (known) chk("read_data", last_rd, e);
      chk("led", {24'h0, led}, {24'h0, m_led});
      chk("fault_count", {16'h0, fault_count}, {16'h0, m_fault});
    end
    @(posedge clk);
    model_edge(rst, we, a, wd, dip);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0, 1:    a = RAM_BASE + 32'(4 * $urandom_range(0, RAM_WORDS - 1));
      2:       a = IO_BASE + 32'(4 * $urandom_range(0, 3));
      3: begin
        case ($urandom_range(0, 3))
          0:       a = RAM_BASE - 32'd4;
          1:       a = RAM_BASE + 32'(4 * RAM_WORDS);
          2:       a = IO_BASE + 32'd16;
          default: a = 32'h0000_4000;
        endcase
      end
      default: a = $urandom;
    endcase
    if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    reset          = 1'b1;
    dip            = 16'h0;
    bif.mem_write  = 1'b0;
    bif.addr       = 32'h0;
    bif.write_data = 32'h0;

    // Reset, then CYCLE reads 0,1,2.
    step(1, 0, 32'h0, 32'h0, 0);
    step(1, 0, 32'h0, 32'h0, 1);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_fault", {16'h0, fault_count}, 32'h0);
    step(0, 0, 32'h0C08, 32'h0, 1); chk("cycle_0", last_rd, 32'd0);
    step(0, 0, 32'h0C08, 32'h0, 1); chk("cycle_1", last_rd, 32'd1);
    step(0, 0, 32'h0C08, 32'h0, 1); chk("cycle_2", last_rd, 32'd2);

    // RAM round trip with same-cycle read of the old value.
    step(0, 1, 32'h0804, 32'h1111_1111, 1);
    step(0, 1, 32'h0804, 32'hDEAD_BEEF, 1); chk("ram_old", last_rd, 32'h1111_1111);
    step(0, 0, 32'h0804, 32'h0, 1);         chk("ram_804", last_rd, 32'hDEAD_BEEF);
    step(0, 0, 32'h0806, 32'h0, 1);         chk("ram_806", last_rd, 32'hDEAD_BEEF);

    // LED write and an unmapped read.
    step(0, 1, 32'h0C00, 32'h1234_56A5, 1); chk("led_a5", {24'h0, led}, 32'hA5);
    step(0, 0, 32'h0C00, 32'h0, 1);         chk("led_rd", last_rd, 32'h0000_00A5);
    step(0, 0, 32'h0000_4000, 32'h0, 1);    chk("unmapped_rd", last_rd, 32'h0);
    chk("unmapped_nofault", {16'h0, fault_count}, 32'h0);

    // Four faulting writes leave storage untouched.
    step(0, 1, 32'h0C04, 32'hFFFF_FFFF, 1);
    step(0, 1, 32'h0C0C, 32'hFFFF_FFFF, 1);
    step(0, 1, 32'h0000_4000, 32'hFFFF_FFFF, 1);
    step(0, 1, 32'h0805, 32'h0BAD_F00D, 1);
    chk("fault_4", {16'h0, fault_count}, 32'd4);
    chk("fault_led", {24'h0, led}, 32'hA5);
    step(0, 0, 32'h0804, 32'h0, 1);         chk("fault_ram", last_rd, 32'hDEAD_BEEF);

    // CYCLE clear and misaligned CYCLE write.
    step(0, 1, 32'h0C08, 32'h0, 1);
    step(0, 0, 32'h0C08, 32'h0, 1);         chk("cycle_clr", last_rd, 32'd0);
    step(0, 1, 32'h0C09, 32'h0, 1);         chk("cycle_mis_rd", last_rd, 32'd1);
    step(0, 0, 32'h0C08, 32'h0, 1);         chk("cycle_noclr", last_rd, 32'd2);
    chk("fault_5", {16'h0, fault_count}, 32'd5);

    // DIP synchroniser: two cycles before the new value is readable.
    dip = 16'hBEEF;
    step(0, 0, 32'h0C04, 32'h0, 1);         chk("dip_n", last_rd, 32'h0);
    step(0, 0, 32'h0C04, 32'h0, 1);         chk("dip_n1", last_rd, 32'h0);
    step(0, 0, 32'h0C04, 32'h0, 1);         chk("dip_n2", last_rd, 32'h0000_BEEF);

    // Reset in the middle of activity wins over a concurrent write.
    step(0, 1, 32'h0C00, 32'h0000_00FF, 1);
    step(0, 1, 32'h0C0C, 32'h0, 1);
    step(0, 1, 32'h0C0C, 32'h0, 1);
    chk("pre_rst_led", {24'h0, led}, 32'hFF);
    chk("pre_rst_fault", {16'h0, fault_count}, 32'd7);
    step(1, 1, 32'h0C00, 32'h0000_003C, 1);
    chk("mid_rst_led", {24'h0, led}, 32'h0);
    chk("mid_rst_fault", {16'h0, fault_count}, 32'h0);
    step(0, 0, 32'h0C08, 32'h0, 1);         chk("mid_rst_cycle", last_rd, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) dip = 16'($urandom);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), rand_addr(), $urandom, 1);
    end

    // Fault counter saturation.
    step(1, 0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 65534; i++) step(0, 1, 32'h0000_4000, 32'h0, 0);
    chk("sat_fffe", {16'h0, fault_count}, 32'h0000_FFFE);
    step(0, 1, 32'h0C04, 32'h0, 1);
    chk("sat_ffff", {16'h0, fault_count}, 32'h0000_FFFF);
    step(0, 1, 32'h0805, 32'h0, 1);
    chk("sat_hold", {16'h0, fault_count}, 32'h0000_FFFF);
    step(0, 0, 32'h0C0C, 32'h0, 1);         chk("sat_rd", last_rd, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
